// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer encodings for the swapping controller and the port arbiter.
package fb_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DISP_RD = 2'd1,
      RAST_WR = 2'd2
   } fb_state_e;

   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;
endpackage

// File: rtl/fb_write_holding_reg.sv
// fb_write_holding_reg: one-entry valid/ready holding register for a raster write {sel, addr, data}.
module fb_write_holding_reg #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 4
) (
   input  logic              i_clk,
   input  logic              i_srst_n,
   input  logic              in_valid,
   input  logic              in_sel,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              pop,
   output logic              full,
   output logic              full_nxt,
   output logic              sel,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);
   logic accept;

   // a pop frees the slot in the same cycle, so a new write can land behind it
   assign in_ready = i_srst_n & (~full | pop);
   assign accept   = in_valid & in_ready;
   assign full_nxt = accept | (full & ~pop);

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         full <= 1'b0;
         sel  <= 1'b0;
         addr <= '0;
         data <= '0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            sel  <= in_sel;
            addr <= in_addr;
            data <= in_data;
         end
      end
   end
endmodule

// File: rtl/frame_buffer_port_arbiter.sv
// frame_buffer_port_arbiter: shares one single-port SRAM holding both frame buffers between
// display reads (priority) and rasterizer writes, with a starvation bound on display streaks.
module frame_buffer_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 4,
   parameter int MAX_DISP_STREAK = 8
) (
   input  logic              i_clk,
   input  logic              i_srst_n,
   input  logic              i_rasterization_target,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic              o_disp_gnt,
   output logic              o_disp_rvalid,
   output logic [DATA_W-1:0] o_disp_rdata,
   input  logic              i_rast_valid,
   input  logic [ADDR_W-1:0] i_rast_addr,
   input  logic [DATA_W-1:0] i_rast_data,
   output logic              o_rast_ready,
   output logic              o_rast_drained,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W:0]   o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);
   localparam int CNT_W = $clog2(MAX_DISP_STREAK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DISP_STREAK);

   fb_state_e         state, state_nxt;
   logic [CNT_W-1:0]  starve_cnt, starve_nxt;
   logic              hold_full, hold_full_nxt, hold_sel;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_data;
   logic              force_wr, disp_win, wr_issue;

   fb_write_holding_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
      .i_clk    (i_clk),
      .i_srst_n (i_srst_n),
      .in_valid (i_rast_valid),
      .in_sel   (i_rasterization_target),
      .in_addr  (i_rast_addr),
      .in_data  (i_rast_data),
      .in_ready (o_rast_ready),
      .pop      (wr_issue),
      .full     (hold_full),
      .full_nxt (hold_full_nxt),
      .sel      (hold_sel),
      .addr     (hold_addr),
      .data     (hold_data)
   );

   always_comb begin
      force_wr   = hold_full & (starve_cnt == CNT_MAX);
      disp_win   = i_srst_n & i_disp_req & ~force_wr;
      wr_issue   = i_srst_n & hold_full & ~disp_win;
      state_nxt  = disp_win ? DISP_RD : (wr_issue ? RAST_WR : IDLE);
      starve_nxt = wr_issue ? '0 :
                   ((disp_win & hold_full & (starve_cnt != CNT_MAX)) ? starve_cnt + CNT_W'(1) : starve_cnt);
   end

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   assign o_disp_gnt   = disp_win;
   // SRAM output is already registered; it is only meaningful in the rvalid cycle
   assign o_disp_rdata = o_disp_rvalid ? i_mem_rdata : '0;

   always_ff @(posedge i_clk) begin
      if (!i_srst_n) begin
         o_mem_en       <= 1'b0;
         o_mem_we       <= 1'b0;
         o_mem_addr     <= '0;
         o_mem_wdata    <= '0;
         o_disp_rvalid  <= 1'b0;
         o_rast_drained <= 1'b1;
      end else begin
         o_mem_en       <= disp_win | wr_issue;
         o_mem_we       <= wr_issue;
         o_disp_rvalid  <= state == DISP_RD;
         o_rast_drained <= ~hold_full_nxt & ~wr_issue;
         if (disp_win)
            o_mem_addr <= {~i_rasterization_target, i_disp_addr};
         else if (wr_issue) begin
            o_mem_addr  <= {hold_sel, hold_addr};
            o_mem_wdata <= hold_data;
         end
      end
   end
endmodule

// File: tb/tb_frame_buffer_port_arbiter.sv
// tb_frame_buffer_port_arbiter: directed vector table, starvation/reset sequences and
// randomized traffic checked against a queue-based reference model.
module tb_frame_buffer_port_arbiter;
   localparam int MAX = 8;
   localparam logic L = 1'b0;
   localparam logic H = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        srst_n, tgt, dreq, rv;
   logic [15:0] daddr, raddr;
   logic [3:0]  rdat;
   logic        gnt, rvalid, ready, drained, en, we;
   logic [3:0]  drdata, wdata, mem_rdata;
   logic [16:0] maddr;

   logic [3:0] sram   [0:131071];
   logic [3:0] shadow [0:131071];

   frame_buffer_port_arbiter #(.ADDR_W(16), .DATA_W(4), .MAX_DISP_STREAK(MAX)) dut (
      .i_clk                  (clk),
      .i_srst_n               (srst_n),
      .i_rasterization_target (tgt),
      .i_disp_req             (dreq),
      .i_disp_addr            (daddr),
      .o_disp_gnt             (gnt),
      .o_disp_rvalid          (rvalid),
      .o_disp_rdata           (drdata),
      .i_rast_valid           (rv),
      .i_rast_addr            (raddr),
      .i_rast_data            (rdat),
      .o_rast_ready           (ready),
      .o_rast_drained         (drained),
      .o_mem_en               (en),
      .o_mem_we               (we),
      .o_mem_addr             (maddr),
      .o_mem_wdata            (wdata),
      .i_mem_rdata            (mem_rdata)
   );

   always @(posedge clk)
      if (en) begin
         if (we) sram[maddr] <= wdata;
         else mem_rdata <= sram[maddr];
      end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic rst_n, tgt, dreq; logic [15:0] daddr; logic rv; logic [15:0] raddr; logic [3:0] rdat;
      logic e_gnt, e_ready, e_en, e_we; logic [16:0] e_addr; logic [3:0] e_wdata;
      logic e_rvalid; logic [3:0] e_rdata; logic e_drained;
   } vec_t;

   typedef struct {
      logic sel; logic [15:0] a; logic [3:0] d;
   } wr_t;

   vec_t tbl[$];
   wr_t  pend[$];

   initial begin
      logic [16:0] x;
      int grants;
      logic seen_wr;
      int streak;
      logic has, forced, m_gnt, m_wr, m_ready, n_rv;
      logic exp_en, exp_we, exp_rvalid, exp_drained;
      logic [16:0] exp_addr;
      logic [3:0] exp_wdata, exp_rdata, n_rd;

      for (int a = 0; a < 131072; a++) begin
         x = 17'(a);
         sram[a] = x[3:0] ^ {x[16], 3'b000};
      end
      srst_n = L; tgt = L; dreq = L; rv = L; daddr = '0; raddr = '0; rdat = '0;

      for (int i = 0; i < 5; i++)
         tbl.push_back('{L,L,H,16'h0,H,16'h5,4'h3, L,L,L,L,17'h0,4'h0,L,4'h0,H});
      tbl.push_back('{H,L,L,16'h0,L,16'h0,4'h0, L,H,L,L,17'h00000,4'h0,L,4'h0,H});
      tbl.push_back('{H,L,H,16'h10,L,16'h0,4'h0, H,H,H,L,17'h10010,4'h0,L,4'h0,H});
      tbl.push_back('{H,L,L,16'h0,L,16'h0,4'h0, L,H,L,L,17'h10010,4'h0,H,4'h8,H});
      tbl.push_back('{H,L,L,16'h0,H,16'h5,4'hA, L,H,L,L,17'h10010,4'h0,L,4'h0,L});
      tbl.push_back('{H,L,L,16'h0,L,16'h0,4'h0, L,H,H,H,17'h00005,4'hA,L,4'h0,L});
      tbl.push_back('{H,L,L,16'h0,L,16'h0,4'h0, L,H,L,L,17'h00005,4'h0,L,4'h0,H});
      tbl.push_back('{H,L,L,16'h0,H,16'h7,4'h5, L,H,L,L,17'h00005,4'h0,L,4'h0,L});
      tbl.push_back('{H,H,L,16'h0,L,16'h0,4'h0, L,H,H,H,17'h00007,4'h5,L,4'h0,L});
      tbl.push_back('{H,H,H,16'h7,L,16'h0,4'h0, H,H,H,L,17'h00007,4'h0,L,4'h0,H});
      tbl.push_back('{H,H,L,16'h0,L,16'h0,4'h0, L,H,L,L,17'h00007,4'h0,H,4'h5,H});
      tbl.push_back('{H,H,L,16'h0,H,16'h9,4'hC, L,H,L,L,17'h00007,4'h0,L,4'h0,L});
      tbl.push_back('{H,H,H,16'h23,L,16'h0,4'h0, H,L,H,L,17'h00023,4'h0,L,4'h0,L});
      tbl.push_back('{H,H,L,16'h0,H,16'hB,4'h3, L,H,H,H,17'h10009,4'hC,H,4'h3,L});
      tbl.push_back('{H,H,L,16'h0,L,16'h0,4'h0, L,H,H,H,17'h1000B,4'h3,L,4'h0,L});
      tbl.push_back('{H,H,L,16'h0,L,16'h0,4'h0, L,H,L,L,17'h1000B,4'h0,L,4'h0,H});

      foreach (tbl[i]) begin
         srst_n = tbl[i].rst_n; tgt = tbl[i].tgt; dreq = tbl[i].dreq; daddr = tbl[i].daddr;
         rv = tbl[i].rv; raddr = tbl[i].raddr; rdat = tbl[i].rdat;
         #1;
         chk($sformatf("t%0d_gnt", i), gnt, tbl[i].e_gnt);
         chk($sformatf("t%0d_ready", i), ready, tbl[i].e_ready);
         @(posedge clk); #1;
         chk($sformatf("t%0d_en", i), en, tbl[i].e_en);
         chk($sformatf("t%0d_we", i), we, tbl[i].e_we);
         chk($sformatf("t%0d_addr", i), maddr, tbl[i].e_addr);
         if (tbl[i].e_we) chk($sformatf("t%0d_wdata", i), wdata, tbl[i].e_wdata);
         chk($sformatf("t%0d_rvalid", i), rvalid, tbl[i].e_rvalid);
         if (tbl[i].e_rvalid) chk($sformatf("t%0d_rdata", i), drdata, tbl[i].e_rdata);
         chk($sformatf("t%0d_drained", i), drained, tbl[i].e_drained);
      end

      // starvation: a write arrives while display keeps requesting
      tgt = L; dreq = H; daddr = 16'h50; rv = H; raddr = 16'h30; rdat = 4'h6;
      #1;
      chk("stv_first_gnt", gnt, 1);
      @(posedge clk); #1;
      rv = L;
      grants = 0; seen_wr = L;
      for (int c = 0; c < 20 && !seen_wr; c++) begin
         if (gnt) grants++;
         else seen_wr = H;
         @(posedge clk); #1;
         if (seen_wr) begin
            chk("stv_wr_en", en, 1);
            chk("stv_wr_we", we, 1);
            chk("stv_wr_addr", maddr, 17'h00030);
            chk("stv_wr_data", wdata, 4'h6);
         end
      end
      chk("stv_grants", grants, MAX);
      chk("stv_wr_seen", seen_wr, 1);
      chk("stv_resume_gnt", gnt, 1);
      @(posedge clk); #1;
      chk("stv_resume_rd", {en, we}, 2'b10);
      dreq = L;
      @(posedge clk); #1;

      // reset between grant and rvalid
      dreq = H; daddr = 16'h40;
      #1;
      chk("rst_gnt", gnt, 1);
      @(posedge clk); #1;
      dreq = L; srst_n = L;
      #1;
      chk("rst_gnt_low", gnt, 0);
      chk("rst_ready_low", ready, 0);
      @(posedge clk); #1;
      chk("rst_rvalid", rvalid, 0);
      chk("rst_en", en, 0);
      chk("rst_we", we, 0);
      chk("rst_addr", maddr, 0);
      chk("rst_rdata", drdata, 0);
      chk("rst_drained", drained, 1);
      @(posedge clk); #1;
      chk("rst_rvalid2", rvalid, 0);
      @(posedge clk); #1;

      // randomized traffic against the reference model
      for (int a = 0; a < 131072; a++) shadow[a] = sram[a];
      pend.delete(); streak = 0;
      exp_en = L; exp_we = L; exp_addr = '0; exp_wdata = '0;
      exp_rvalid = L; exp_rdata = '0; exp_drained = H;
      for (int c = 0; c < 3000; c++) begin
         srst_n = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 15) == 0) tgt = ~tgt;
         dreq  = ($urandom_range(0, 3) != 0);
         daddr = 16'($urandom_range(0, 15));
         rv    = $urandom_range(0, 1) != 0;
         raddr = 16'($urandom_range(0, 15));
         rdat  = 4'($urandom_range(0, 15));
         #1;
         has     = pend.size() > 0;
         forced  = has && streak >= MAX;
         m_gnt   = srst_n && dreq && !forced;
         m_wr    = srst_n && has && !m_gnt;
         m_ready = srst_n && (!has || m_wr);
         chk("rnd_gnt", gnt, m_gnt);
         chk("rnd_ready", ready, m_ready);
         n_rv = exp_en && !exp_we;
         n_rd = n_rv ? shadow[exp_addr] : 4'h0;
         if (exp_en && exp_we) shadow[exp_addr] = exp_wdata;
         if (!srst_n) begin
            pend.delete(); streak = 0;
            exp_en = L; exp_we = L; exp_addr = '0; exp_wdata = '0;
            exp_rvalid = L; exp_rdata = '0; exp_drained = H;
         end else begin
            exp_rvalid = n_rv; exp_rdata = n_rd;
            exp_en = m_gnt || m_wr; exp_we = m_wr;
            if (m_gnt) begin
               exp_addr = {~tgt, daddr};
               if (has && streak < MAX) streak++;
            end
            if (m_wr) begin
               exp_addr = {pend[0].sel, pend[0].a};
               exp_wdata = pend[0].d;
               void'(pend.pop_front());
               streak = 0;
            end
            if (rv && m_ready) pend.push_back('{tgt, raddr, rdat});
            exp_drained = pend.size() == 0 && !m_wr;
         end
         @(posedge clk); #1;
         chk("rnd_en", en, exp_en);
         chk("rnd_we", we, exp_we);
         if (exp_en) chk("rnd_addr", maddr, exp_addr);
         if (exp_we) chk("rnd_wdata", wdata, exp_wdata);
         chk("rnd_rvalid", rvalid, exp_rvalid);
         chk("rnd_rdata", drdata, exp_rdata);
         chk("rnd_drained", drained, exp_drained);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
